// File: rtl/alu_arbiter.sv
// ============================================================================
// Module      : alu_arbiter
// Description : Round-robin arbiter that shares one ALU between NREQ clients,
//               with a watchdog that aborts and resets a hung ALU operation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [6*NREQ-1:0] req_op,
  input  logic [16*NREQ-1:0] req_a,
  input  logic [16*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              err,
  output logic [15:0]       res_x,
  output logic [15:0]       res_y,
  output logic [3:0]        res_flags,
  output logic              busy,
  output logic              alu_bgn,
  output logic [5:0]        alu_opcode,
  output logic [15:0]       alu_a,
  output logic [15:0]       alu_b,
  output logic              alu_srst,
  input  logic [15:0]       alu_acc1,
  input  logic [15:0]       alu_acc2,
  input  logic              alu_zero,
  input  logic              alu_neg,
  input  logic              alu_carry,
  input  logic              alu_ovf,
  input  logic              alu_rdy
);

  localparam int          PW         = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [5:0]  c_nop      = {5'b11111, 1'b0};
  localparam logic [7:0]  c_wd_last  = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_ABORT = 3'd4,
    S_FLUSH = 3'd5
  } state_t;

  state_t          r_state;
  logic [PW-1:0]   r_ptr;
  logic [7:0]      r_wd;
  logic            r_rdy_low;

  logic            w_found;
  int              w_idx;

  // Search starts just after the last winner, so the previous owner ranks last.
  always_comb begin
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!w_found && req[(int'(r_ptr) + k) % NREQ]) begin
        w_found = 1'b1;
        w_idx   = (int'(r_ptr) + k) % NREQ;
      end
    end
  end

  assign busy = (r_state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ptr      <= PW'(NREQ - 1);
      r_wd       <= '0;
      r_rdy_low  <= 1'b0;
      gnt        <= '0;
      done       <= '0;
      err        <= 1'b0;
      res_x      <= '0;
      res_y      <= '0;
      res_flags  <= '0;
      alu_bgn    <= 1'b0;
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_srst   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            gnt        <= NREQ'(1) << w_idx;
            r_ptr      <= PW'(w_idx);
            alu_opcode <= req_op[6*w_idx +: 6];
            alu_a      <= req_a[16*w_idx +: 16];
            alu_b      <= req_b[16*w_idx +: 16];
            alu_bgn    <= 1'b1;
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          alu_bgn   <= 1'b0;
          r_rdy_low <= 1'b0;
          r_wd      <= '0;
          r_state   <= S_WAIT;
        end
        S_WAIT: begin
          if (!alu_rdy) r_rdy_low <= 1'b1;
          // rdy only counts once it has been seen low since the strobe
          if (alu_rdy && r_rdy_low) begin
            res_x     <= alu_acc1;
            res_y     <= alu_acc2;
            res_flags <= {alu_zero, alu_neg, alu_carry, alu_ovf};
            done      <= gnt;
            r_state   <= S_DONE;
          end else if (r_wd == c_wd_last) begin
            done      <= gnt;
            err       <= 1'b1;
            res_x     <= '0;
            res_y     <= '0;
            res_flags <= '0;
            alu_srst  <= 1'b1;
            r_state   <= S_ABORT;
          end else begin
            r_wd <= r_wd + 8'd1;
          end
        end
        S_DONE: begin
          done    <= '0;
          gnt     <= '0;
          r_state <= S_IDLE;
        end
        S_ABORT: begin
          done       <= '0;
          err        <= 1'b0;
          gnt        <= '0;
          alu_opcode <= c_nop;
          r_state    <= S_FLUSH;
        end
        S_FLUSH: begin
          alu_srst <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
